// File: rtl/starship_pkg.sv
// Shared constants for the starship fault controller: one-hot channel state
// encoding, default parameter values and counter sizing helpers.
package starship_pkg;

  // Default parameter values used by the controller and its channels.
  localparam int DEF_NUM_CH       = 3;
  localparam int DEF_COMBO_W      = 4;
  localparam int DEF_ARM_TICKS    = 2;
  localparam int DEF_REPAIR_TICKS = 60;
  localparam int DEF_COOL_TICKS   = 4;
  localparam int DEF_MAX_BROKEN   = 2;

  // One-hot channel state encoding: bit positions and the state constants.
  localparam int ST_W       = 5;
  localparam int S_INIT     = 0;
  localparam int S_ARM      = 1;
  localparam int S_WORKING  = 2;
  localparam int S_REPAIR   = 3;
  localparam int S_COOLDOWN = 4;

  localparam logic [ST_W-1:0] ST_INIT     = 5'b00001;
  localparam logic [ST_W-1:0] ST_ARM      = 5'b00010;
  localparam logic [ST_W-1:0] ST_WORKING  = 5'b00100;
  localparam logic [ST_W-1:0] ST_REPAIR   = 5'b01000;
  localparam logic [ST_W-1:0] ST_COOLDOWN = 5'b10000;

  typedef logic [ST_W-1:0] chan_state_t;

  // Largest of three tick budgets.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width of a tick counter able to hold the largest tick budget.
  function automatic int cnt_width(input int arm, input int rep, input int cool);
    return $clog2(max3(arm, rep, cool) + 1);
  endfunction

endpackage

// File: rtl/starship_fault_chan.sv
// One breakable subsystem: lifecycle FSM, tick counter, latched repair combo
// and sticky deadline-miss flag. Arbitration is done by the parent.
module starship_fault_chan
  import starship_pkg::*;
#(
  parameter int COMBO_W      = DEF_COMBO_W,
  parameter int ARM_TICKS    = DEF_ARM_TICKS,
  parameter int REPAIR_TICKS = DEF_REPAIR_TICKS,
  parameter int COOL_TICKS   = DEF_COOL_TICKS
) (
  input  logic               timer_clk,
  input  logic               Reset,
  input  logic               play_i,
  input  logic               gameover_i,
  input  logic               grant_i,
  input  logic [COMBO_W-1:0] random_hex_i,
  input  logic               sel_hit_i,
  input  logic [COMBO_W-1:0] hex_combo_i,
  input  logic               override_i,
  output logic               working_o,
  output logic               broken_o,
  output logic [COMBO_W-1:0] combo_o,
  output logic               expired_o,
  output logic               miss_o
);

  localparam int CNT_W = cnt_width(ARM_TICKS, REPAIR_TICKS, COOL_TICKS);
  localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPAIR_TICKS - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  chan_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic               expired_q, expired_d;

  // Next-state logic for the channel lifecycle; gameover wins over everything.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    combo_d   = combo_q;
    expired_d = expired_q;
    miss_o    = 1'b0;
    if (gameover_i) begin
      state_d   = ST_INIT;
      cnt_d     = '0;
      combo_d   = '0;
      expired_d = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_d     = '0;
          combo_d   = '0;
          expired_d = 1'b0;
          if (play_i) state_d = ST_ARM;
        end
        ST_ARM: begin
          if (cnt_q >= ARM_LAST) begin
            state_d = ST_WORKING;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_WORKING: begin
          if (grant_i) begin
            state_d = ST_REPAIR;
            combo_d = random_hex_i;
            cnt_d   = '0;
          end
        end
        ST_REPAIR: begin
          if (override_i || (sel_hit_i && (hex_combo_i == combo_q))) begin
            state_d = ST_COOLDOWN;
            cnt_d   = '0;
          end else begin
            miss_o = sel_hit_i;
            // Counter parks at the deadline; the miss flag is raised once it is there.
            if (cnt_q >= REP_LAST) expired_d = 1'b1;
            else                   cnt_d     = cnt_q + CNT_ONE;
          end
        end
        ST_COOLDOWN: begin
          if (cnt_q >= COOL_LAST) begin
            state_d = ST_WORKING;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d   = ST_INIT;
          cnt_d     = '0;
          combo_d   = '0;
          expired_d = 1'b0;
        end
      endcase
    end
  end

  // Channel state registers with asynchronous clear.
  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      combo_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      combo_q   <= combo_d;
      expired_q <= expired_d;
    end
  end

  assign working_o = state_q[S_WORKING];
  assign broken_o  = state_q[S_REPAIR];
  assign combo_o   = combo_q;
  assign expired_o = expired_q;

endmodule

// File: rtl/starship_fault_ctrl.sv
// Starship fault controller: NUM_CH breakable channels, break-grant arbitration
// limited to MAX_BROKEN simultaneous faults, and a saturating wrong-submit count.
module starship_fault_ctrl
  import starship_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int COMBO_W      = DEF_COMBO_W,
  parameter int ARM_TICKS    = DEF_ARM_TICKS,
  parameter int REPAIR_TICKS = DEF_REPAIR_TICKS,
  parameter int COOL_TICKS   = DEF_COOL_TICKS,
  parameter int MAX_BROKEN   = DEF_MAX_BROKEN
) (
  input  logic                      timer_clk,
  input  logic                      Reset,
  input  logic                      play,
  input  logic                      gameover,
  input  logic [NUM_CH-1:0]         break_req,
  input  logic [COMBO_W-1:0]        random_hex,
  input  logic [NUM_CH-1:0]         repair_sel,
  input  logic                      submit,
  input  logic [COMBO_W-1:0]        hex_combo,
  input  logic                      override,
  output logic [NUM_CH-1:0]         broken,
  output logic [NUM_CH*COMBO_W-1:0] combo,
  output logic [NUM_CH-1:0]         expired,
  output logic [7:0]                wrong_cnt,
  output logic                      any_expired
);

  logic [NUM_CH-1:0] working;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] sel_hit;
  logic [NUM_CH-1:0] miss;
  logic              sel_onehot;
  logic [7:0]        wrong_cnt_q, wrong_cnt_d;

  // A submit addresses a channel only when exactly one select bit is set.
  assign sel_onehot = $onehot(repair_sel);
  assign sel_hit    = (submit && sel_onehot) ? repair_sel : '0;

  // Grant breaks in ascending channel order until the broken limit is reached.
  always_comb begin
    int n_busy;
    grant  = '0;
    n_busy = $countones(broken);
    for (int i = 0; i < NUM_CH; i++) begin
      if (break_req[i] && working[i] && (n_busy < MAX_BROKEN)) begin
        grant[i] = 1'b1;
        n_busy   = n_busy + 1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    starship_fault_chan #(
      .COMBO_W      (COMBO_W),
      .ARM_TICKS    (ARM_TICKS),
      .REPAIR_TICKS (REPAIR_TICKS),
      .COOL_TICKS   (COOL_TICKS)
    ) u_chan (
      .timer_clk    (timer_clk),
      .Reset        (Reset),
      .play_i       (play),
      .gameover_i   (gameover),
      .grant_i      (grant[g]),
      .random_hex_i (random_hex),
      .sel_hit_i    (sel_hit[g]),
      .hex_combo_i  (hex_combo),
      .override_i   (override),
      .working_o    (working[g]),
      .broken_o     (broken[g]),
      .combo_o      (combo[g*COMBO_W +: COMBO_W]),
      .expired_o    (expired[g]),
      .miss_o       (miss[g])
    );
  end

  // Wrong-submit count: cleared on gameover (entry to INIT), saturates at 255.
  always_comb begin
    wrong_cnt_d = wrong_cnt_q;
    if (gameover)                          wrong_cnt_d = '0;
    else if ((|miss) && (wrong_cnt_q != 8'hFF)) wrong_cnt_d = wrong_cnt_q + 8'd1;
  end

  // Wrong-submit count register.
  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) wrong_cnt_q <= '0;
    else       wrong_cnt_q <= wrong_cnt_d;
  end

  assign wrong_cnt   = wrong_cnt_q;
  assign any_expired = |expired;

endmodule

// File: tb/tb_starship_fault_ctrl.sv
// Self-checking bench for starship_fault_ctrl: directed scenarios followed by a
// random phase, all compared against a timestamp-based behavioural model.
module tb_starship_fault_ctrl;

  localparam int NUM_CH       = 3;
  localparam int COMBO_W      = 4;
  localparam int ARM_TICKS    = 2;
  localparam int REPAIR_TICKS = 60;
  localparam int COOL_TICKS   = 4;
  localparam int MAX_BROKEN   = 2;

  logic                      timer_clk;
  logic                      Reset;
  logic                      play;
  logic                      gameover;
  logic [NUM_CH-1:0]         break_req;
  logic [COMBO_W-1:0]        random_hex;
  logic [NUM_CH-1:0]         repair_sel;
  logic                      submit;
  logic [COMBO_W-1:0]        hex_combo;
  logic                      override;
  logic [NUM_CH-1:0]         broken;
  logic [NUM_CH*COMBO_W-1:0] combo;
  logic [NUM_CH-1:0]         expired;
  logic [7:0]                wrong_cnt;
  logic                      any_expired;

  int n_tests = 0;
  int n_fail  = 0;

  starship_fault_ctrl #(
    .NUM_CH       (NUM_CH),
    .COMBO_W      (COMBO_W),
    .ARM_TICKS    (ARM_TICKS),
    .REPAIR_TICKS (REPAIR_TICKS),
    .COOL_TICKS   (COOL_TICKS),
    .MAX_BROKEN   (MAX_BROKEN)
  ) dut (
    .timer_clk   (timer_clk),
    .Reset       (Reset),
    .play        (play),
    .gameover    (gameover),
    .break_req   (break_req),
    .random_hex  (random_hex),
    .repair_sel  (repair_sel),
    .submit      (submit),
    .hex_combo   (hex_combo),
    .override    (override),
    .broken      (broken),
    .combo       (combo),
    .expired     (expired),
    .wrong_cnt   (wrong_cnt),
    .any_expired (any_expired)
  );

  initial timer_clk = 1'b0;
  always #5 timer_clk = ~timer_clk;

  // Behavioural model: each channel is a mode plus the edge number it entered it.
  typedef enum int {M_IDLE, M_ARMING, M_RUN, M_BROKEN, M_COOL} mode_e;
  mode_e              m_mode  [NUM_CH];
  int                 m_ent   [NUM_CH];
  logic [COMBO_W-1:0] m_combo [NUM_CH];
  logic               m_exp   [NUM_CH];
  int                 m_wrong;
  int                 edge_n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_mode[i]  = M_IDLE;
      m_ent[i]   = 0;
      m_combo[i] = '0;
      m_exp[i]   = 1'b0;
    end
    m_wrong = 0;
    edge_n  = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    int k;
    int nb;
    logic [NUM_CH-1:0] gr;
    bit sel_ok;
    k = edge_n + 1;
    edge_n = k;
    if (gameover) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_mode[i]  = M_IDLE;
        m_combo[i] = '0;
        m_exp[i]   = 1'b0;
      end
      m_wrong = 0;
      return;
    end
    nb = 0;
    for (int i = 0; i < NUM_CH; i++) if (m_mode[i] == M_BROKEN) nb++;
    gr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_mode[i] == M_RUN && break_req[i] && nb < MAX_BROKEN) begin
        gr[i] = 1'b1;
        nb++;
      end
    end
    sel_ok = submit && ($countones(repair_sel) == 1);
    for (int i = 0; i < NUM_CH; i++) begin
      case (m_mode[i])
        M_IDLE:   if (play) begin m_mode[i] = M_ARMING; m_ent[i] = k; end
        M_ARMING: if (k - m_ent[i] >= ARM_TICKS) begin m_mode[i] = M_RUN; m_ent[i] = k; end
        M_RUN: if (gr[i]) begin
          m_mode[i] = M_BROKEN; m_ent[i] = k; m_combo[i] = random_hex;
        end
        M_BROKEN: begin
          if (override || (sel_ok && repair_sel[i] && hex_combo == m_combo[i])) begin
            m_mode[i] = M_COOL; m_ent[i] = k;
          end else begin
            if (sel_ok && repair_sel[i] && m_wrong < 255) m_wrong++;
            if (k - m_ent[i] >= REPAIR_TICKS) m_exp[i] = 1'b1;
          end
        end
        M_COOL: if (k - m_ent[i] >= COOL_TICKS) begin m_mode[i] = M_RUN; m_ent[i] = k; end
        default: m_mode[i] = M_IDLE;
      endcase
    end
  endtask

  task automatic check_outputs();
    logic [NUM_CH-1:0]         e_broken;
    logic [NUM_CH-1:0]         e_exp;
    logic [NUM_CH*COMBO_W-1:0] e_combo;
    for (int i = 0; i < NUM_CH; i++) begin
      e_broken[i]                = (m_mode[i] == M_BROKEN);
      e_exp[i]                   = m_exp[i];
      e_combo[i*COMBO_W +: COMBO_W] = m_combo[i];
    end
    check("broken",      64'(broken),      64'(e_broken));
    check("combo",       64'(combo),       64'(e_combo));
    check("expired",     64'(expired),     64'(e_exp));
    check("wrong_cnt",   64'(wrong_cnt),   64'(m_wrong));
    check("any_expired", 64'(any_expired), 64'(|e_exp));
  endtask

  // One clock: model consumes current inputs, DUT clocks, outputs sampled 1 ns later.
  task automatic tick();
    model_step();
    @(posedge timer_clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    play       = 1'b0;
    gameover   = 1'b0;
    break_req  = '0;
    random_hex = '0;
    repair_sel = '0;
    submit     = 1'b0;
    hex_combo  = '0;
    override   = 1'b0;
  endtask

  initial begin
    int ch;
    Reset = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge timer_clk);
    #1;
    check("reset_broken",  64'(broken),      64'd0);
    check("reset_combo",   64'(combo),       64'd0);
    check("reset_expired", 64'(expired),     64'd0);
    check("reset_wrong",   64'(wrong_cnt),   64'd0);
    check("reset_anyexp",  64'(any_expired), 64'd0);

    // Release reset with play already high: the first edge must start the game.
    Reset = 1'b0;
    play  = 1'b1;
    tick();
    play      = 1'b0;
    break_req = 3'b001;
    tick();
    check("arm_t1_no_break", 64'(broken), 64'd0);
    tick();
    check("arm_t2_no_break", 64'(broken), 64'd0);
    random_hex = 4'hA;
    tick();
    check("t3_broken", 64'(broken), 64'b001);
    check("t3_combo0", 64'(combo[3:0]), 64'hA);

    // Repair channel 0, let it cool down, then break it again with combo 5.
    break_req  = '0;
    submit     = 1'b1;
    repair_sel = 3'b001;
    hex_combo  = 4'hA;
    tick();
    submit = 1'b0;
    repeat (COOL_TICKS) tick();
    break_req  = 3'b001;
    random_hex = 4'h5;
    tick();
    check("rebreak_combo0", 64'(combo[3:0]), 64'h5);
    break_req  = '0;
    submit     = 1'b1;
    repair_sel = 3'b001;
    hex_combo  = 4'h3;
    tick();
    check("wrong_submit_cnt",    64'(wrong_cnt), 64'd1);
    check("wrong_submit_broken", 64'(broken),    64'b001);
    repair_sel = 3'b011;
    tick();
    check("multisel_ignored", 64'(wrong_cnt), 64'd1);
    repair_sel = 3'b001;
    hex_combo  = 4'h5;
    tick();
    check("right_submit_fix", 64'(broken), 64'b000);
    submit    = 1'b0;
    break_req = 3'b001;
    repeat (COOL_TICKS) begin
      tick();
      check("cooldown_immune", 64'(broken), 64'b000);
    end
    check("combo_held", 64'(combo[3:0]), 64'h5);
    break_req = '0;
    tick();

    // All three request at once: only the two lowest indices are granted.
    break_req  = 3'b111;
    random_hex = 4'h7;
    tick();
    check("grant_limit", 64'(broken), 64'b011);
    break_req = '0;

    // Fix channel 0, leave channel 1 to run out its deadline.
    submit     = 1'b1;
    repair_sel = 3'b001;
    hex_combo  = 4'h7;
    tick();
    submit = 1'b0;
    repeat (REPAIR_TICKS - 3) tick();
    check("before_deadline", 64'(expired), 64'b000);
    repeat (2) tick();
    check("deadline_expired", 64'(expired),     64'b010);
    check("deadline_anyexp",  64'(any_expired), 64'd1);
    check("deadline_stays",   64'(broken),      64'b010);
    submit     = 1'b1;
    repair_sel = 3'b010;
    hex_combo  = 4'h7;
    tick();
    check("late_fix_broken", 64'(broken),  64'b000);
    check("late_fix_sticky", 64'(expired), 64'b010);
    submit = 1'b0;

    // Two channels broken, then gameover (with play ignored in the same tick).
    repeat (COOL_TICKS) tick();
    break_req  = 3'b101;
    random_hex = 4'hC;
    tick();
    check("two_broken", 64'(broken), 64'b101);
    break_req = '0;
    gameover  = 1'b1;
    play      = 1'b1;
    tick();
    check("gameover_broken",  64'(broken),    64'd0);
    check("gameover_wrong",   64'(wrong_cnt), 64'd0);
    check("gameover_expired", 64'(expired),   64'd0);
    gameover = 1'b0;
    play     = 1'b0;
    tick();

    // Random phase against the model.
    play = 1'b1;
    tick();
    for (int n = 0; n < 600; n++) begin
      play       = ($urandom_range(0, 15) == 0);
      gameover   = ($urandom_range(0, 99) == 0);
      break_req  = NUM_CH'($urandom) & NUM_CH'($urandom);
      random_hex = COMBO_W'($urandom);
      submit     = ($urandom_range(0, 3) == 0);
      override   = ($urandom_range(0, 31) == 0);
      hex_combo  = COMBO_W'($urandom);
      if ($urandom_range(0, 9) < 7) begin
        ch         = $urandom_range(0, NUM_CH - 1);
        repair_sel = NUM_CH'(1 << ch);
        if ($urandom_range(0, 1) == 1) hex_combo = m_combo[ch];
      end else begin
        repair_sel = NUM_CH'($urandom);
      end
      tick();
    end

    // Saturation of the wrong-submit count.
    idle_inputs();
    gameover = 1'b1;
    tick();
    gameover = 1'b0;
    play     = 1'b1;
    tick();
    play = 1'b0;
    repeat (ARM_TICKS) tick();
    break_req  = 3'b001;
    random_hex = 4'h1;
    tick();
    check("sat_setup_broken", 64'(broken), 64'b001);
    break_req  = '0;
    submit     = 1'b1;
    repair_sel = 3'b001;
    hex_combo  = 4'h2;
    repeat (256) tick();
    check("wrong_saturated", 64'(wrong_cnt), 64'd255);

    // Reset asserted between edges must clear outputs without waiting for a clock.
    #3;
    Reset = 1'b1;
    #1;
    model_reset();
    check("async_broken",  64'(broken),      64'd0);
    check("async_combo",   64'(combo),       64'd0);
    check("async_expired", 64'(expired),     64'd0);
    check("async_wrong",   64'(wrong_cnt),   64'd0);
    check("async_anyexp",  64'(any_expired), 64'd0);
    @(posedge timer_clk);
    #1;
    check_outputs();
    Reset = 1'b0;
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/starship_fault_ctrl.md
STARSHIP_FAULT_CTRL -- requirements
Module: starship_fault_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of independent breakable subsystems.
REQ-002 SHALL have parameter COMBO_W, default 4: repair-combo width.
REQ-003 SHALL have parameter ARM_TICKS, default 2: grace ticks after play before a channel may break.
REQ-004 SHALL have parameter REPAIR_TICKS, default 60: repair deadline in ticks.
REQ-005 SHALL have parameter COOL_TICKS, default 4: post-repair immunity ticks.
REQ-006 SHALL have parameter MAX_BROKEN, default 2: maximum number of channels broken at once.
REQ-007 SHALL have ports:
- timer_clk in 1: clock.
- Reset in 1: reset, asynchronous, active-high.
- play in 1: game start.
- gameover in 1: abort to INIT.
- break_req in NUM_CH: per-channel random break pulse.
- random_hex in COMBO_W: combo source.
- repair_sel in NUM_CH: one-hot channel being repaired.
- submit in 1: single-tick combo-submit pulse.
- hex_combo in COMBO_W: player entry.
- override in 1: debug repair.
- broken out NUM_CH: channel in REPAIR.
- combo out NUM_CH*COMBO_W: latched combos, channel i at bits [i*COMBO_W +: COMBO_W].
- expired out NUM_CH: sticky deadline miss.
- wrong_cnt out 8: wrong-submit count.
- any_expired out 1: OR of expired.

Function
REQ-008 Each channel SHALL run FSM INIT -> ARM -> WORKING -> REPAIR -> COOLDOWN -> WORKING, one tick per transition.
REQ-009 INIT: play=1 -> ARM; channel tick counter, combo and expired SHALL be cleared.
REQ-010 ARM: counter increments each tick; at count ARM_TICKS-1 -> WORKING; break_req SHALL be ignored.
REQ-011 WORKING: break_req[i]=1 and granted (REQ-012) -> REPAIR next tick; combo[i] <= random_hex; counter cleared.
REQ-012 Grant: broken count (current) plus grants this tick SHALL not exceed MAX_BROKEN; competing requests SHALL be granted in ascending index order; ungranted requests SHALL be dropped, not queued.
REQ-013 REPAIR: submit with repair_sel[i]=1 and hex_combo==combo[i] -> COOLDOWN; mismatch -> wrong_cnt+1, stays REPAIR.
REQ-014 wrong_cnt SHALL saturate at 255 and clear only on Reset or entry to INIT.
REQ-015 REPAIR: override=1 -> COOLDOWN, taking priority over submit.
REQ-016 REPAIR: counter reaching REPAIR_TICKS-1 SHALL set expired[i] (sticky until INIT); channel stays in REPAIR.
REQ-017 COOLDOWN: after COOL_TICKS ticks -> WORKING; break_req ignored throughout.
REQ-018 gameover=1 SHALL force every channel to INIT next tick, overriding all other conditions; play is ignored in the same tick.
REQ-019 broken[i] SHALL equal (state==REPAIR), registered, with no combinational path from inputs.
REQ-020 combo[i] SHALL hold its value through COOLDOWN and WORKING until the next break or INIT.
REQ-021 repair_sel with multiple bits set SHALL be treated as no selection: submit is ignored and wrong_cnt unchanged.
REQ-022 Counters SHALL be clog2(max(ARM_TICKS,REPAIR_TICKS,COOL_TICKS)+1) bits wide and SHALL not wrap in any state.

Reset
REQ-023 Reset SHALL asynchronously force all channels to INIT and clear broken, combo, expired, wrong_cnt, any_expired and counters to 0.
REQ-024 Reset release SHALL take effect on the first timer_clk edge with Reset low; play sampled on that edge SHALL be honoured.

Structure
REQ-025 The state encoding (one-hot INIT/ARM/WORKING/REPAIR/COOLDOWN) and default parameter constants SHALL reside in shared package starship_pkg.
REQ-026 The per-channel FSM and counter SHALL be sub-module starship_fault_chan, instantiated NUM_CH times.
REQ-027 Grant arbitration and wrong_cnt SHALL reside in the top level.

Verification
REQ-028 Reset; play tick 0; break_req=3'b001 at ticks 1..2 -> no break; at tick 3 with random_hex=4'hA -> broken=001, combo[0]=A.
REQ-029 Channel 0 broken with combo 5; submit with sel=001, hex=3 -> wrong_cnt=1, broken unchanged; submit with hex=5 -> broken=000; break_req[0] over the next 4 ticks -> no break.
REQ-030 All channels WORKING; break_req=3'b111 in one tick -> broken=3'b011, channel 2 stays WORKING.
REQ-031 Channel 1 broken, no input for 60 ticks -> expired=010 and any_expired=1; a correct submit after that -> COOLDOWN, expired still 010.
REQ-032 Two channels broken; gameover=1 -> next tick all INIT, broken=0, wrong_cnt=0, expired=0.
REQ-033 Reset asserted mid-REPAIR between clock edges -> outputs 0 immediately; 256 wrong submits -> wrong_cnt=255.
